valu_seq: RTL and testbench
===========================

VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-002 The block SHALL have parameter ELEMENTS, default 8, elements per vector.
REQ-003 The block SHALL have parameter LANES, default 2, elements processed per cycle; ELEMENTS SHALL be an integer multiple of LANES.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid_in  input  1  request valid.
REQ-007 The block SHALL have port req_ready_o  output  1  request accepted when high with req_valid_in.
REQ-008 The block SHALL have port valu_op_in  input  4  opcode: 0 VADD, 1 VSUB, 2 VSLL, 3 VSLT, 4 VSLTU, 5 VXOR, 6 VSRL, 7 VSRA, 8 VOR, 9 VAND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-009 The block SHALL have ports vrs1_data_in and vrs2_data_in  input  [ELEMENTS] x DATA_WIDTH  operand vectors.
REQ-010 The block SHALL have port resp_valid_o  output  1  result valid.
REQ-011 The block SHALL have port resp_ready_in  input  1  consumer ready.
REQ-012 The block SHALL have port valu_res_o  output  [ELEMENTS] x DATA_WIDTH  result vector.
REQ-013 The block SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; req_ready_o SHALL be high only in IDLE.
REQ-015 On req_valid_in && req_ready_o the block SHALL capture opcode and both operand vectors, clear the element-group counter, and enter EXEC; inputs SHALL be ignored after capture.
REQ-016 In EXEC, each cycle SHALL compute elements [cnt*LANES +: LANES] from the captured operands and write them into the result register, then increment cnt.
REQ-017 When the last group is written (cnt == ELEMENTS/LANES-1), the FSM SHALL enter DONE; resp_valid_o SHALL rise exactly ELEMENTS/LANES clocks after the accepting edge (4 for defaults).
REQ-018 In DONE, resp_valid_o SHALL stay high and valu_res_o SHALL stay stable until resp_ready_in is high; on that handshake the FSM SHALL return to IDLE on the same edge, so no new request is accepted in that cycle.
REQ-019 Ops 0-9 SHALL use RV32 semantics modulo 2^DATA_WIDTH; shift amount SHALL be rs2[log2(DATA_WIDTH)-1:0]; VSLT/VSLTU SHALL return 1 or 0 zero-extended.
REQ-020 Ops 10-15 SHALL return per element 1 if the condition holds, else 0 (signed for BLT/BGE, unsigned for BLTU/BGEU).
REQ-021 Element positions not yet computed in EXEC SHALL retain their prior register value; valu_res_o is valid only when resp_valid_o is high.

Reset
REQ-022 While rst_n is low: state IDLE, cnt 0, all result elements 0, resp_valid_o 0, busy_o 0, req_ready_o 1 (regardless of req_valid_in).
REQ-023 Reset asserted in EXEC or DONE SHALL abort the operation immediately, with no response ever issued for it.

Configuration
REQ-024 With macro VALU_SEQ_PERF_EN defined, the block SHALL add output perf_ops_o (32 bits) counting completed response handshakes, reset to 0, wrapping from 0xFFFFFFFF to 0.
REQ-025 Without VALU_SEQ_PERF_EN, perf_ops_o and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-026 VADD, rs1 = rs2 = {1..8}, resp_ready high -> result {2,4,6,8,10,12,14,16}; resp_valid_o high 4 clocks after accept.
REQ-027 VSUB element 0: 3 - 5 -> 0xFFFFFFFE; VSRA 0x80000000 by 4 -> 0xF8000000; VSRL same -> 0x08000000.
REQ-028 BLT: -1 vs 1 -> 1; BLTU: 0xFFFFFFFF vs 1 -> 0; BGEU: 5 vs 5 -> 1.
REQ-029 resp_ready_in low 3 cycles in DONE -> resp_valid_o held, result unchanged, req_ready_o 0, new req_valid_in not accepted.
REQ-030 rst_n pulsed low during the 2nd EXEC cycle -> resp_valid_o 0, result all 0, req_ready_o 1; the next request completes correctly.
REQ-031 With VALU_SEQ_PERF_EN, 3 back-to-back ops -> perf_ops_o = 3; reset -> 0.

Source files
------------

// File: rtl/valu_seq_if.sv
// -----------------------------------------------------------------------------
// valu_seq_if -- request/response bundle for the sequential vector ALU.
//
// Request side : req_valid_in / req_ready_o handshake carrying the opcode
//                (valu_op_in) and two operand vectors (vrs1/vrs2_data_in).
// Response side: resp_valid_o / resp_ready_in handshake carrying the result
//                vector (valu_res_o).
// Status       : busy_o, high whenever the engine is not idle.
//
// Modports:
//   master -- the requester (drives requests, consumes responses)
//   slave  -- the vector ALU itself
// -----------------------------------------------------------------------------
interface valu_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8
);

  logic                                 req_valid_in;
  logic                                 req_ready_o;
  logic [3:0]                           valu_op_in;
  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  vrs1_data_in;
  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  vrs2_data_in;
  logic                                 resp_valid_o;
  logic                                 resp_ready_in;
  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  valu_res_o;
  logic                                 busy_o;

  modport master (
    output req_valid_in, valu_op_in, vrs1_data_in, vrs2_data_in, resp_ready_in,
    input  req_ready_o, resp_valid_o, valu_res_o, busy_o
  );

  modport slave (
    input  req_valid_in, valu_op_in, vrs1_data_in, vrs2_data_in, resp_ready_in,
    output req_ready_o, resp_valid_o, valu_res_o, busy_o
  );

endinterface

// File: rtl/valu_seq.sv
// -----------------------------------------------------------------------------
// valu_seq -- sequential element-wise vector ALU.
//
// A request captures an opcode and two ELEMENTS-wide operand vectors. The
// engine then processes LANES elements per clock (ELEMENTS/LANES cycles),
// writing each group into the result register, and finally presents the whole
// result vector until the consumer accepts it.
//
// Parameters:
//   DATA_WIDTH -- element width in bits
//   ELEMENTS   -- elements per vector
//   LANES      -- elements computed per cycle (ELEMENTS must be a multiple)
//
// Ports:
//   clk        -- sole clock, rising edge
//   rst_n      -- asynchronous active-low reset; aborts any operation
//   bus        -- valu_seq_if.slave (request, response and busy status)
//   perf_ops_o -- (only with VALU_SEQ_PERF_EN) count of completed response
//                 handshakes, 32 bits, wraps
//
// Opcodes: 0 VADD, 1 VSUB, 2 VSLL, 3 VSLT, 4 VSLTU, 5 VXOR, 6 VSRL, 7 VSRA,
//          8 VOR, 9 VAND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
//          Branch-style opcodes yield 1/0 per element.
//
// Optional feature macro: VALU_SEQ_PERF_EN (adds perf_ops_o).
// -----------------------------------------------------------------------------
module valu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8,
  parameter int LANES      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  valu_seq_if.slave   bus
`ifdef VALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops_o
`endif
);

  localparam int GROUPS = ELEMENTS / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SH_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_VADD  = 4'd0,
    OP_VSUB  = 4'd1,
    OP_VSLL  = 4'd2,
    OP_VSLT  = 4'd3,
    OP_VSLTU = 4'd4,
    OP_VXOR  = 4'd5,
    OP_VSRL  = 4'd6,
    OP_VSRA  = 4'd7,
    OP_VOR   = 4'd8,
    OP_VAND  = 4'd9,
    OP_BEQ   = 4'd10,
    OP_BNE   = 4'd11,
    OP_BLT   = 4'd12,
    OP_BGE   = 4'd13,
    OP_BLTU  = 4'd14,
    OP_BGEU  = 4'd15
  } op_t;

  // Vectors are held grouped by lane so that a whole group is addressed by
  // the group counter alone; the bit layout matches the flat port vectors.
  typedef logic [LANES-1:0][DATA_WIDTH-1:0]             lane_vec_t;
  typedef logic [GROUPS-1:0][LANES-1:0][DATA_WIDTH-1:0] grp_vec_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  op_t              op_q;
  grp_vec_t         op1_q, op2_q;
  grp_vec_t         res_q;
  lane_vec_t        lane_res;
  logic             accept;
  logic             resp_done;

  // ---------------------------------------------------------------------------
  // Single-element operation.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] elem_op(
    input op_t                   op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [SH_W-1:0]       sh;
    logic [DATA_WIDTH-1:0] r;
    sh = b[SH_W-1:0];
    r  = '0;
    case (op)
      OP_VADD:  r = a + b;
      OP_VSUB:  r = a - b;
      OP_VSLL:  r = a << sh;
      OP_VSLT:  r = DATA_WIDTH'($signed(a) < $signed(b));
      OP_VSLTU: r = DATA_WIDTH'(a < b);
      OP_VXOR:  r = a ^ b;
      OP_VSRL:  r = a >> sh;
      OP_VSRA:  r = $unsigned($signed(a) >>> sh);
      OP_VOR:   r = a | b;
      OP_VAND:  r = a & b;
      OP_BEQ:   r = DATA_WIDTH'(a == b);
      OP_BNE:   r = DATA_WIDTH'(a != b);
      OP_BLT:   r = DATA_WIDTH'($signed(a) < $signed(b));
      OP_BGE:   r = DATA_WIDTH'($signed(a) >= $signed(b));
      OP_BLTU:  r = DATA_WIDTH'(a < b);
      OP_BGEU:  r = DATA_WIDTH'(a >= b);
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && bus.req_valid_in;
  assign resp_done = (state_q == DONE) && bus.resp_ready_in;

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.busy_o       = 1'b1;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        bus.busy_o      = 1'b0;
        if (bus.req_valid_in) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == LAST_GRP) state_d = DONE;
      end
      DONE: begin
        bus.resp_valid_o = 1'b1;
        // Returning straight to IDLE here means the earliest new accept is the
        // following edge; ready is low for the whole DONE cycle.
        if (bus.resp_ready_in) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane datapath: LANES elements of the current group.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_res = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_res[l] = elem_op(op_q, op1_q[cnt_q][l], op2_q[cnt_q][l]);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture. Only read while EXEC, after a capture has happened, so
  // these registers carry no reset.
  // ---------------------------------------------------------------------------
  // NOTE: large data-only registers are deliberately left out of reset; the
  // result register below is reset because its zero value is visible on the
  // port straight out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op_t'(bus.valu_op_in);
      op1_q <= bus.vrs1_data_in;
      op2_q <= bus.vrs2_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Group counter and result register. Groups not yet written keep whatever
  // the previous operation left there.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == EXEC) begin
        res_q[cnt_q] <= lane_res;
        cnt_q        <= (cnt_q == LAST_GRP) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign bus.valu_res_o = res_q;

`ifdef VALU_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Completed-response counter, free-running with natural wrap.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (resp_done) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_ops_o = perf_q;
`else
  // Handshake completion is only consumed by the optional counter.
  logic unused_resp_done;
  assign unused_resp_done = resp_done;
`endif

endmodule

// File: tb/tb_valu_seq.sv
// -----------------------------------------------------------------------------
// tb_valu_seq -- self-checking bench for valu_seq (default parameters).
//
// A table of {opcode, operands, expected result} records covers all sixteen
// opcodes; hand-written sequences cover result retention during EXEC,
// response back-pressure, reset in mid-operation and (with VALU_SEQ_PERF_EN)
// the completion counter.
// -----------------------------------------------------------------------------
module tb_valu_seq;

  localparam int DW = 32;
  localparam int NE = 8;
  localparam int NL = 2;
  localparam int EXP_LAT = NE / NL;

  typedef logic [NE-1:0][DW-1:0] vec_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    vec_t       a;
    vec_t       b;
    vec_t       exp;
  } vec_rec_t;

  logic clk;
  logic rst_n;

  valu_seq_if #(.DATA_WIDTH(DW), .ELEMENTS(NE)) bus ();

`ifdef VALU_SEQ_PERF_EN
  logic [31:0] perf_ops;
`endif

  valu_seq #(
    .DATA_WIDTH (DW),
    .ELEMENTS   (NE),
    .LANES      (NL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef VALU_SEQ_PERF_EN
    ,
    .perf_ops_o (perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int perf_exp = 0;

  vec_rec_t tbl [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [31:0] e4, input logic [31:0] e5,
                              input logic [31:0] e6, input logic [31:0] e7);
    vec_t v;
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    v[4] = e4; v[5] = e5; v[6] = e6; v[7] = e7;
    return v;
  endfunction

  // Present a request on a falling edge, let the next rising edge accept it,
  // then scramble the inputs to show they are ignored after capture.
  task automatic start_op(input logic [3:0] op, input vec_t a, input vec_t b, input string name);
    @(negedge clk);
    bus.req_valid_in = 1'b1;
    bus.valu_op_in   = op;
    bus.vrs1_data_in = a;
    bus.vrs2_data_in = b;
    check({name, " req_ready"}, bus.req_ready_o, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid_in = 1'b0;
    bus.valu_op_in   = ~op;
    bus.vrs1_data_in = ~a;
    bus.vrs2_data_in = ~b;
  endtask

  // Wait (bounded) for resp_valid_o; lat counts rising edges from now.
  task automatic wait_resp(input vec_t exp, input int exp_lat, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.resp_valid_o) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({name, " resp_valid seen"}, seen, 1'b1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, bus.valu_res_o, exp);
  endtask

  // Complete the response handshake (resp_ready_in is high) and check IDLE.
  task automatic finish_resp(input string name);
    bus.resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    perf_exp++;
    check({name, " idle valid"}, bus.resp_valid_o, 1'b0);
    check({name, " idle busy"}, bus.busy_o, 1'b0);
  endtask

  task automatic run_vec(input int i);
    start_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].name);
    check({tbl[i].name, " busy"}, bus.busy_o, 1'b1);
    wait_resp(tbl[i].exp, EXP_LAT, tbl[i].name);
    finish_resp(tbl[i].name);
  endtask

  initial begin
    vec_t add_a, sub_a, sub_b, sh_a, sh_b, sll_a, sll_b, slt_a, slt_b;
    vec_t lg_a, lg_b, br_a, br_b, prev, snap;
    bit seen;

    add_a = mk(1, 2, 3, 4, 5, 6, 7, 8);
    sub_a = mk(3, 10, 0, 100, 7, 32'h8000_0000, 1, 0);
    sub_b = mk(5, 3, 1, 100, 0, 1, 2, 0);
    sh_a  = mk(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0,
               32'h8000_0000, 1, 32'hFFFF_FFFF, 32'h1234_5678);
    sh_b  = mk(4, 0, 31, 2, 31, 1, 36, 33);
    sll_a = mk(1, 1, 3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 5, 1);
    sll_b = mk(0, 31, 4, 1, 1, 4, 32, 33);
    slt_a = mk(32'hFFFF_FFFF, 1, 5, 32'h8000_0000, 0, 32'h7FFF_FFFF, 3, 32'hFFFF_FFFE);
    slt_b = mk(1, 32'hFFFF_FFFF, 5, 32'h7FFF_FFFF, 0, 32'h8000_0000, 4, 32'hFFFF_FFFF);
    lg_a  = mk(32'hF0F0_F0F0, 32'hFFFF_FFFF, 0, 32'h1234_5678, 32'hAAAA_AAAA, 1, 2, 3);
    lg_b  = mk(32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'h5555_5555, 1, 3, 5);
    br_a  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1, 32'h8000_0000, 7, 0, 3);
    br_b  = mk(1, 1, 5, 2, 32'h7FFF_FFFF, 7, 32'hFFFF_FFFF, 2);

    tbl[0]  = '{"VADD",  4'd0,  add_a, add_a, mk(2, 4, 6, 8, 10, 12, 14, 16)};
    tbl[1]  = '{"VSUB",  4'd1,  sub_a, sub_b, mk(32'hFFFF_FFFE, 7, 32'hFFFF_FFFF, 0, 7,
                                                 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0)};
    tbl[2]  = '{"VSLL",  4'd2,  sll_a, sll_b, mk(1, 32'h8000_0000, 32'h30, 32'hFFFF_FFFE,
                                                 0, 32'h2345_6780, 5, 2)};
    tbl[3]  = '{"VSLT",  4'd3,  slt_a, slt_b, mk(1, 0, 0, 1, 0, 0, 1, 1)};
    tbl[4]  = '{"VSLTU", 4'd4,  slt_a, slt_b, mk(0, 1, 0, 0, 0, 1, 1, 1)};
    tbl[5]  = '{"VXOR",  4'd5,  lg_a,  lg_b,  mk(32'hFFFF_FFFF, 0, 0, 32'hEDCB_A987,
                                                 32'hFFFF_FFFF, 0, 1, 6)};
    tbl[6]  = '{"VSRL",  4'd6,  sh_a,  sh_b,  mk(32'h0800_0000, 32'h8000_0000, 0, 32'h3FFF_FFFC,
                                                 1, 0, 32'h0FFF_FFFF, 32'h091A_2B3C)};
    tbl[7]  = '{"VSRA",  4'd7,  sh_a,  sh_b,  mk(32'hF800_0000, 32'h8000_0000, 0, 32'hFFFF_FFFC,
                                                 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'h091A_2B3C)};
    tbl[8]  = '{"VOR",   4'd8,  lg_a,  lg_b,  mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF,
                                                 32'hFFFF_FFFF, 1, 3, 7)};
    tbl[9]  = '{"VAND",  4'd9,  lg_a,  lg_b,  mk(0, 32'hFFFF_FFFF, 0, 32'h1234_5678, 0, 1, 2, 1)};
    tbl[10] = '{"BEQ",   4'd10, br_a,  br_b,  mk(0, 0, 1, 0, 0, 1, 0, 0)};
    tbl[11] = '{"BNE",   4'd11, br_a,  br_b,  mk(1, 1, 0, 1, 1, 0, 1, 1)};
    tbl[12] = '{"BLT",   4'd12, br_a,  br_b,  mk(1, 1, 0, 1, 1, 0, 0, 0)};
    tbl[13] = '{"BGE",   4'd13, br_a,  br_b,  mk(0, 0, 1, 0, 0, 1, 1, 1)};
    tbl[14] = '{"BLTU",  4'd14, br_a,  br_b,  mk(0, 0, 0, 1, 0, 0, 1, 0)};
    tbl[15] = '{"BGEU",  4'd15, br_a,  br_b,  mk(1, 1, 1, 0, 1, 1, 0, 1)};

    // ---- Reset state, with a request pending ----
    rst_n             = 1'b0;
    bus.req_valid_in  = 1'b1;
    bus.valu_op_in    = 4'd0;
    bus.vrs1_data_in  = add_a;
    bus.vrs2_data_in  = add_a;
    bus.resp_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", bus.req_ready_o, 1'b1);
    check("reset resp_valid", bus.resp_valid_o, 1'b0);
    check("reset busy", bus.busy_o, 1'b0);
    check("reset result", bus.valu_res_o, '0);
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    rst_n            = 1'b1;
`ifdef VALU_SEQ_PERF_EN
    #1;
    check("reset perf", perf_ops, 0);
`endif

    // ---- Every opcode from the table ----
    for (int i = 0; i < 16; i++) run_vec(i);

    // ---- Untouched groups keep the previous result during EXEC ----
    run_vec(0);
    prev = tbl[0].exp;
    start_op(tbl[1].op, tbl[1].a, tbl[1].b, "retain");
    check("retain before write", bus.valu_res_o, prev);
    @(posedge clk);
    #1;
    snap = bus.valu_res_o;
    check("retain group0 new", snap[1:0], tbl[1].exp[1:0]);
    check("retain rest old", snap[7:2], prev[7:2]);
    wait_resp(tbl[1].exp, EXP_LAT - 1, "retain");
    finish_resp("retain");

    // ---- Back-pressure: consumer stalls three cycles in DONE ----
    bus.resp_ready_in = 1'b0;
    start_op(tbl[7].op, tbl[7].a, tbl[7].b, "stall");
    wait_resp(tbl[7].exp, EXP_LAT, "stall");
    bus.req_valid_in = 1'b1;
    bus.valu_op_in   = 4'd0;
    bus.vrs1_data_in = add_a;
    bus.vrs2_data_in = add_a;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("stall resp_valid", bus.resp_valid_o, 1'b1);
      check("stall result", bus.valu_res_o, tbl[7].exp);
      check("stall req_ready", bus.req_ready_o, 1'b0);
    end
    bus.resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    perf_exp++;
    check("stall release valid", bus.resp_valid_o, 1'b0);
    check("stall no accept on handshake", bus.busy_o, 1'b0);
    check("stall ready after", bus.req_ready_o, 1'b1);
    bus.req_valid_in = 1'b0;

    // ---- Reset in the second EXEC cycle aborts the operation ----
    start_op(tbl[0].op, tbl[0].a, tbl[0].b, "abort");
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    bus.req_valid_in = 1'b1;
    #1;
    check("abort resp_valid", bus.resp_valid_o, 1'b0);
    check("abort result", bus.valu_res_o, '0);
    check("abort req_ready", bus.req_ready_o, 1'b1);
    check("abort busy", bus.busy_o, 1'b0);
    perf_exp = 0;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    rst_n            = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid_o) seen = 1'b1;
    end
    check("abort no response", seen, 1'b0);
    run_vec(3);

`ifdef VALU_SEQ_PERF_EN
    check("perf count", perf_ops, perf_exp);
`endif

    // ---- Reset, then three back-to-back operations ----
    @(negedge clk);
    rst_n = 1'b0;
    perf_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef VALU_SEQ_PERF_EN
    check("perf after reset", perf_ops, 0);
`endif
    run_vec(12);
    run_vec(14);
    run_vec(15);
`ifdef VALU_SEQ_PERF_EN
    check("perf three ops", perf_ops, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
